// File: rtl/axil_bram_bridge.sv
// axil_bram_bridge
//   Dual-port word memory. Port A is an AXI4-lite slave mapped at
//   BASE_ADDR. Port B is a native synchronous port used by the UDP
//   packet engine. Both ports are read-first, and port B wins a
//   same-word write collision.
//
// Ports
//   sclk, reset            clock and synchronous active-high reset
//   bram_axi_aw*           write address channel (one-entry holding register)
//   bram_axi_w*            write data channel (one-entry holding register)
//   bram_axi_b*            write response channel
//   bram_axi_ar*           read address channel
//   bram_axi_r*            read data/response channel (one-cycle latency)
//   pb_*                   native port B: enable, write-enable, word index, data
//   err_cnt_o              saturating count of SLVERR responses handed off
module axil_bram_bridge #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                     sclk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        bram_axi_awaddr_i,
    input  logic                     bram_axi_awvalid_i,
    output logic                     bram_axi_awready_o,
    input  logic [DATA_W-1:0]        bram_axi_wdata_i,
    input  logic [DATA_W/8-1:0]      bram_axi_wstrb_i,
    input  logic                     bram_axi_wvalid_i,
    output logic                     bram_axi_wready_o,
    output logic [1:0]               bram_axi_bresp_o,
    output logic                     bram_axi_bvalid_o,
    input  logic                     bram_axi_bready_i,
    input  logic [ADDR_W-1:0]        bram_axi_araddr_i,
    input  logic                     bram_axi_arvalid_i,
    output logic                     bram_axi_arready_o,
    output logic [DATA_W-1:0]        bram_axi_rdata_o,
    output logic [1:0]               bram_axi_rresp_o,
    output logic                     bram_axi_rvalid_o,
    input  logic                     bram_axi_rready_i,
    input  logic                     pb_en_i,
    input  logic                     pb_we_i,
    input  logic [$clog2(DEPTH)-1:0] pb_addr_i,
    input  logic [DATA_W-1:0]        pb_wdata_i,
    output logic [DATA_W-1:0]        pb_rdata_o,
    output logic [15:0]              err_cnt_o
);

    localparam int BYTES    = DATA_W / 8;
    localparam int OFF_BITS = $clog2(BYTES);
    localparam int IDX_W    = $clog2(DEPTH);
    // Window size carries one extra bit so a window reaching the top of
    // the address space does not wrap to zero.
    localparam logic [ADDR_W:0] WIN_BYTES   = (ADDR_W+1)'(DEPTH * BYTES);
    localparam logic [1:0]      RESP_OKAY   = 2'b00;
    localparam logic [1:0]      RESP_SLVERR = 2'b10;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              aw_full_q,  aw_full_d;
    logic [ADDR_W-1:0] aw_addr_q,  aw_addr_d;
    logic              w_full_q,   w_full_d;
    logic [DATA_W-1:0] w_data_q,   w_data_d;
    logic [BYTES-1:0]  w_strb_q,   w_strb_d;
    logic              bvalid_q,   bvalid_d;
    logic [1:0]        bresp_q,    bresp_d;
    logic              rvalid_q,   rvalid_d;
    logic [1:0]        rresp_q,    rresp_d;
    logic [DATA_W-1:0] rdata_q,    rdata_d;
    logic [DATA_W-1:0] pb_rdata_q, pb_rdata_d;
    logic [15:0]       err_cnt_q,  err_cnt_d;

    logic              awready, wready, arready;
    logic              aw_hs, w_hs, ar_hs, b_hs, r_hs, commit;
    logic [ADDR_W-1:0] aw_off, ar_off;
    logic              aw_in_range, ar_in_range;
    logic [IDX_W-1:0]  aw_idx, ar_idx;
    logic [1:0]        err_inc;
    logic [16:0]       err_sum;

    // Offsets are taken relative to the window base; an address below
    // the base wraps to a large offset but is rejected by the >= test.
    assign aw_off      = aw_addr_q - BASE_ADDR;
    assign aw_in_range = (aw_addr_q >= BASE_ADDR) && ({1'b0, aw_off} < WIN_BYTES);
    assign aw_idx      = aw_off[OFF_BITS +: IDX_W];

    assign ar_off      = bram_axi_araddr_i - BASE_ADDR;
    assign ar_in_range = (bram_axi_araddr_i >= BASE_ADDR) && ({1'b0, ar_off} < WIN_BYTES);
    assign ar_idx      = ar_off[OFF_BITS +: IDX_W];

    // A committed write owns port A for the cycle, so AR waits behind it.
    assign commit  = aw_full_q && w_full_q && (!bvalid_q || bram_axi_bready_i) && !reset;
    assign awready = !aw_full_q && !reset;
    assign wready  = !w_full_q && !reset;
    assign arready = !rvalid_q && !commit && !reset;

    assign aw_hs = bram_axi_awvalid_i && awready;
    assign w_hs  = bram_axi_wvalid_i && wready;
    assign ar_hs = bram_axi_arvalid_i && arready;
    assign b_hs  = bvalid_q && bram_axi_bready_i;
    assign r_hs  = rvalid_q && bram_axi_rready_i;

    always_comb begin
        aw_full_d  = aw_full_q;
        aw_addr_d  = aw_addr_q;
        w_full_d   = w_full_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        pb_rdata_d = pb_rdata_q;

        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end
        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_addr_d = bram_axi_awaddr_i;
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = bram_axi_wdata_i;
            w_strb_d = bram_axi_wstrb_i;
        end

        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = aw_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (b_hs) begin
            bvalid_d = 1'b0;
        end

        // Memory is sampled before this edge's writes land: read-first.
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = ar_in_range ? RESP_OKAY : RESP_SLVERR;
            rdata_d  = ar_in_range ? mem[ar_idx] : '0;
        end else if (r_hs) begin
            rvalid_d = 1'b0;
        end

        if (pb_en_i) begin
            pb_rdata_d = mem[pb_addr_i];
        end

        err_inc   = {1'b0, b_hs && (bresp_q == RESP_SLVERR)}
                  + {1'b0, r_hs && (rresp_q == RESP_SLVERR)};
        err_sum   = {1'b0, err_cnt_q} + 17'(err_inc);
        err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    always_ff @(posedge sclk) begin
        if (reset) begin
            aw_full_q  <= 1'b0;
            aw_addr_q  <= '0;
            w_full_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
            pb_rdata_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            aw_full_q  <= aw_full_d;
            aw_addr_q  <= aw_addr_d;
            w_full_q   <= w_full_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            pb_rdata_q <= pb_rdata_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Port B is written last so it overrides port A on a same-word collision.
    always_ff @(posedge sclk) begin
        if (commit && aw_in_range) begin
            for (int b = 0; b < BYTES; b++) begin
                if (w_strb_q[b]) begin
                    mem[aw_idx][8*b +: 8] <= w_data_q[8*b +: 8];
                end
            end
        end
        if (pb_en_i && pb_we_i && !reset) begin
            mem[pb_addr_i] <= pb_wdata_i;
        end
    end

    assign bram_axi_awready_o = awready;
    assign bram_axi_wready_o  = wready;
    assign bram_axi_arready_o = arready;
    assign bram_axi_bvalid_o  = bvalid_q;
    assign bram_axi_bresp_o   = bresp_q;
    assign bram_axi_rvalid_o  = rvalid_q;
    assign bram_axi_rresp_o   = rresp_q;
    assign bram_axi_rdata_o   = rdata_q;
    assign pb_rdata_o         = pb_rdata_q;
    assign err_cnt_o          = err_cnt_q;

endmodule
